// File: rtl/ball_motion_sched.sv
// ============================================================================
//  Module      : ball_motion_sched
//  Description : Per-frame motion sequencer for up to CNT balls. On every
//                frame tick it walks the ball slots in index order, moves
//                each active ball by its velocity, bounces it off the side
//                walls and the ceiling, and retires it when it falls through
//                the floor. New balls are loaded from a launch request
//                interface while idle.
//  Options     : `define BALL_PADDLE_BOUNCE_EN adds paddle_x/paddle_w/paddle_y
//                inputs and a paddle bounce that overrides floor loss.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ball_motion_sched #(
    parameter int CNT   = 3,
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     frame_tick,
    input  logic [5:0]                               radius,
    input  logic                                     launch_req,
    input  logic [9:0]                               launch_x,
    input  logic [9:0]                               launch_y,
    input  logic [3:0]                               launch_vx,
    input  logic [3:0]                               launch_vy,
`ifdef BALL_PADDLE_BOUNCE_EN
    input  logic [9:0]                               paddle_x,
    input  logic [7:0]                               paddle_w,
    input  logic [9:0]                               paddle_y,
`endif
    output logic                                     launch_ack,
    output logic                                     launch_full,
    output logic [CNT*10-1:0]                        xs,
    output logic [CNT*10-1:0]                        ys,
    output logic [CNT-1:0]                           balls,
    output logic                                     busy,
    output logic                                     lost,
    output logic [((CNT > 1) ? $clog2(CNT) : 1)-1:0] lost_idx,
    output logic                                     overrun
);

    localparam int IDX_W = (CNT > 1) ? $clog2(CNT) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_NEXT  = 2'd3;

    localparam logic signed [11:0] C_X_MAX    = 12'(H_RES - 1);
    localparam logic signed [11:0] C_Y_MAX    = 12'(V_RES - 1);
    localparam logic [IDX_W-1:0]   C_LAST_IDX = IDX_W'(CNT - 1);

    // A velocity of -8 has no positive counterpart in 4 bits, so it is
    // clamped to -7 to keep every negation in range.
    function automatic logic signed [3:0] sat_vel(input logic [3:0] v);
        return (v == 4'b1000) ? 4'sb1001 : $signed(v);
    endfunction

    logic [1:0]              r_state;
    logic [IDX_W-1:0]        r_idx;
    logic signed [3:0]       r_vx [CNT];
    logic signed [3:0]       r_vy [CNT];

    // Results of CALC, held for the WRITE cycle
    logic [9:0]              r_cx;
    logic [9:0]              r_cy;
    logic signed [3:0]       r_cvx;
    logic signed [3:0]       r_cvy;
    logic                    r_clost;

    logic [9:0]              w_cur_x;
    logic [9:0]              w_cur_y;
    logic signed [3:0]       w_cur_vx;
    logic signed [3:0]       w_cur_vy;
    logic signed [11:0]      w_rad;
    logic signed [11:0]      w_nx;
    logic signed [11:0]      w_ny;
    logic signed [11:0]      w_nx_lo;
    logic signed [11:0]      w_nx_hi;
    logic signed [11:0]      w_ny_lo;
    logic signed [11:0]      w_ny_hi;
    logic [9:0]              w_new_x;
    logic [9:0]              w_new_y;
    logic signed [3:0]       w_new_vx;
    logic signed [3:0]       w_new_vy;
    logic                    w_new_lost;
    logic                    w_pad_hit;
    logic                    w_free_any;
    logic [IDX_W-1:0]        w_free_idx;

    assign w_cur_x  = xs[r_idx*10 +: 10];
    assign w_cur_y  = ys[r_idx*10 +: 10];
    assign w_cur_vx = r_vx[r_idx];
    assign w_cur_vy = r_vy[r_idx];
    assign w_rad    = $signed({6'b000000, radius});
    assign w_nx     = $signed({2'b00, w_cur_x}) + $signed({{8{w_cur_vx[3]}}, w_cur_vx});
    assign w_ny     = $signed({2'b00, w_cur_y}) + $signed({{8{w_cur_vy[3]}}, w_cur_vy});
    assign w_nx_lo  = w_nx - w_rad;
    assign w_nx_hi  = w_nx + w_rad;
    assign w_ny_lo  = w_ny - w_rad;
    assign w_ny_hi  = w_ny + w_rad;

`ifdef BALL_PADDLE_BOUNCE_EN
    logic [10:0] w_pad_end;
    assign w_pad_end = {1'b0, paddle_x} + {3'b000, paddle_w};
    assign w_pad_hit = (w_ny_hi >= $signed({2'b00, paddle_y}))
                     && (w_cur_x >= paddle_x)
                     && ({1'b0, w_cur_x} < w_pad_end);
`else
    assign w_pad_hit = 1'b0;
`endif

    // Next position/velocity of the current slot; x and y are independent
    always_comb begin
        w_new_x    = w_nx[9:0];
        w_new_vx   = w_cur_vx;
        w_new_y    = w_ny[9:0];
        w_new_vy   = w_cur_vy;
        w_new_lost = 1'b0;
        if ((w_nx_lo < 12'sd0) || (w_nx_hi > C_X_MAX)) begin
            w_new_x  = w_cur_x;
            w_new_vx = -w_cur_vx;
        end
        if (w_ny_lo < 12'sd0) begin
            w_new_y  = w_cur_y;
            w_new_vy = -w_cur_vy;
        end else if (w_pad_hit) begin
            // Paddle always sends the ball upward, whatever its direction
            w_new_y  = w_cur_y;
            w_new_vy = w_cur_vy[3] ? w_cur_vy : -w_cur_vy;
        end else if (w_ny_hi > C_Y_MAX) begin
            w_new_lost = 1'b1;
        end
    end

    // Lowest-index free slot for a launch
    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        for (int i = CNT - 1; i >= 0; i--) begin
            if (!balls[i]) begin
                w_free_any = 1'b1;
                w_free_idx = IDX_W'(i);
            end
        end
    end

    // Sequencer FSM, slot storage and status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            xs          <= '0;
            ys          <= '0;
            balls       <= '0;
            busy        <= 1'b0;
            launch_ack  <= 1'b0;
            launch_full <= 1'b0;
            lost        <= 1'b0;
            lost_idx    <= '0;
            overrun     <= 1'b0;
            r_cx        <= '0;
            r_cy        <= '0;
            r_cvx       <= '0;
            r_cvy       <= '0;
            r_clost     <= 1'b0;
            for (int i = 0; i < CNT; i++) begin
                r_vx[i] <= '0;
                r_vy[i] <= '0;
            end
        end else begin
            launch_ack  <= 1'b0;
            launch_full <= 1'b0;
            lost        <= 1'b0;
            if (frame_tick && (r_state != S_IDLE)) begin
                overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (frame_tick) begin
                        r_idx   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_CALC;
                    end else if (launch_req) begin
                        if (w_free_any) begin
                            xs[w_free_idx*10 +: 10] <= launch_x;
                            ys[w_free_idx*10 +: 10] <= launch_y;
                            r_vx[w_free_idx]        <= sat_vel(launch_vx);
                            r_vy[w_free_idx]        <= sat_vel(launch_vy);
                            balls[w_free_idx]       <= 1'b1;
                            launch_ack              <= 1'b1;
                        end else begin
                            launch_full <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    if (!balls[r_idx]) begin
                        r_state <= S_NEXT;
                    end else begin
                        r_cx    <= w_new_x;
                        r_cy    <= w_new_y;
                        r_cvx   <= w_new_vx;
                        r_cvy   <= w_new_vy;
                        r_clost <= w_new_lost;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_vx[r_idx] <= r_cvx;
                    r_vy[r_idx] <= r_cvy;
                    if (r_clost) begin
                        balls[r_idx] <= 1'b0;
                        lost         <= 1'b1;
                        lost_idx     <= r_idx;
                    end else begin
                        xs[r_idx*10 +: 10] <= r_cx;
                        ys[r_idx*10 +: 10] <= r_cy;
                    end
                    r_state <= S_NEXT;
                end
                default: begin
                    if (r_idx == C_LAST_IDX) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_idx   <= r_idx + 1'b1;
                        r_state <= S_CALC;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ball_motion_sched.sv
// ============================================================================
//  Module      : tb_ball_motion_sched
//  Description : Directed self-checking bench for ball_motion_sched.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ball_motion_sched;

    localparam int CNT = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            frame_tick;
    logic [5:0]      radius;
    logic            launch_req;
    logic [9:0]      launch_x;
    logic [9:0]      launch_y;
    logic [3:0]      launch_vx;
    logic [3:0]      launch_vy;
    logic            launch_ack;
    logic            launch_full;
    logic [CNT*10-1:0] xs;
    logic [CNT*10-1:0] ys;
    logic [CNT-1:0]  balls;
    logic            busy;
    logic            lost;
    logic [1:0]      lost_idx;
    logic            overrun;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ball_motion_sched #(.CNT(CNT), .H_RES(640), .V_RES(480)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .radius(radius),
        .launch_req(launch_req), .launch_x(launch_x), .launch_y(launch_y),
        .launch_vx(launch_vx), .launch_vy(launch_vy),
        .launch_ack(launch_ack), .launch_full(launch_full),
        .xs(xs), .ys(ys), .balls(balls), .busy(busy), .lost(lost),
        .lost_idx(lost_idx), .overrun(overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] sx(input int i);
        return xs[i*10 +: 10];
    endfunction

    function automatic logic [9:0] sy(input int i);
        return ys[i*10 +: 10];
    endfunction

    task automatic do_reset();
        rst_n      = 1'b0;
        frame_tick = 1'b0;
        launch_req = 1'b0;
        launch_x   = '0;
        launch_y   = '0;
        launch_vx  = '0;
        launch_vy  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Holds the request until ack or full is seen, then drops it
    task automatic do_launch(input logic [9:0] x, input logic [9:0] y,
                             input logic [3:0] vx, input logic [3:0] vy,
                             output logic got_ack, output logic got_full);
        launch_x   = x;
        launch_y   = y;
        launch_vx  = vx;
        launch_vy  = vy;
        launch_req = 1'b1;
        got_ack    = 1'b0;
        got_full   = 1'b0;
        for (int i = 0; i < 20 && !got_ack && !got_full; i++) begin
            @(negedge clk);
            got_ack  = launch_ack;
            got_full = launch_full;
        end
        launch_req = 1'b0;
    endtask

    task automatic do_frame(output int cyc, output int nlost, output logic [1:0] lidx);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("busy_rise", {31'b0, busy}, 32'd1);
        cyc   = 0;
        nlost = 0;
        lidx  = 2'd3;
        while (busy === 1'b1 && cyc < 40) begin
            if (lost === 1'b1) begin
                nlost++;
                lidx = lost_idx;
            end
            @(negedge clk);
            cyc++;
        end
        check("frame_latency_ok", {31'b0, (cyc <= 3*CNT+1)}, 32'd1);
    endtask

    initial begin
        logic       ack, full, seen_ack;
        int         cyc, nlost;
        logic [1:0] lidx;

        radius = 6'd8;
        do_reset();

        // Reset state
        check("rst_xs", xs, 0);
        check("rst_ys", ys, 0);
        check("rst_balls", {29'b0, balls}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_ack", {31'b0, launch_ack}, 0);
        check("rst_full", {31'b0, launch_full}, 0);
        check("rst_lost", {31'b0, lost}, 0);
        check("rst_overrun", {31'b0, overrun}, 0);

        // Basic launch and move
        do_launch(10'd100, 10'd100, 4'd3, 4'b1110, ack, full);
        check("l1_ack", {31'b0, ack}, 1);
        check("l1_balls", {29'b0, balls}, 3'b001);
        check("l1_x", sx(0), 100);
        check("l1_y", sy(0), 100);
        @(negedge clk);
        check("l1_ack_pulse", {31'b0, launch_ack}, 0);
        do_frame(cyc, nlost, lidx);
        check("mv_x", sx(0), 103);
        check("mv_y", sy(0), 98);
        check("mv_nolost", nlost, 0);

        // Right wall bounce
        do_reset();
        radius = 6'd8;
        do_launch(10'd630, 10'd100, 4'd5, 4'd0, ack, full);
        do_frame(cyc, nlost, lidx);
        check("rw_x1", sx(0), 630);
        do_frame(cyc, nlost, lidx);
        check("rw_x2", sx(0), 625);
        check("rw_y2", sy(0), 100);

        // Corner double bounce
        do_reset();
        radius = 6'd4;
        do_launch(10'd5, 10'd5, 4'b1101, 4'b1101, ack, full);
        do_frame(cyc, nlost, lidx);
        check("cn_x1", sx(0), 5);
        check("cn_y1", sy(0), 5);
        do_frame(cyc, nlost, lidx);
        check("cn_x2", sx(0), 8);
        check("cn_y2", sy(0), 8);

        // Floor loss in slot 1
        do_reset();
        radius = 6'd8;
        do_launch(10'd50, 10'd50, 4'd1, 4'd1, ack, full);
        do_launch(10'd200, 10'd470, 4'd0, 4'd4, ack, full);
        do_launch(10'd300, 10'd60, 4'b1111, 4'd0, ack, full);
        check("fl_balls0", {29'b0, balls}, 3'b111);
        do_frame(cyc, nlost, lidx);
        check("fl_nlost", nlost, 1);
        check("fl_idx", {30'b0, lidx}, 1);
        check("fl_balls", {29'b0, balls}, 3'b101);
        check("fl_x0", sx(0), 51);
        check("fl_y0", sy(0), 51);
        check("fl_x1", sx(1), 200);
        check("fl_y1", sy(1), 470);
        check("fl_x2", sx(2), 299);
        check("fl_y2", sy(2), 60);

        // Refill lowest slot with -8 velocity, then full rejection
        do_launch(10'd10, 10'd20, 4'b1000, 4'd0, ack, full);
        check("rf_ack", {31'b0, ack}, 1);
        check("rf_balls", {29'b0, balls}, 3'b111);
        check("rf_x1", sx(1), 10);
        do_launch(10'd400, 10'd400, 4'd1, 4'd1, ack, full);
        check("full_ack", {31'b0, ack}, 0);
        check("full_full", {31'b0, full}, 1);
        check("full_balls", {29'b0, balls}, 3'b111);
        check("full_x1", sx(1), 10);
        @(negedge clk);
        check("full_pulse", {31'b0, launch_full}, 0);
        do_frame(cyc, nlost, lidx);
        check("sat_x1", sx(1), 10);
        do_frame(cyc, nlost, lidx);
        check("sat_x2", sx(1), 17);

        // frame_tick has priority over a simultaneous launch
        do_reset();
        radius = 6'd8;
        do_launch(10'd100, 10'd100, 4'd1, 4'd1, ack, full);
        launch_x   = 10'd300;
        launch_y   = 10'd300;
        launch_vx  = 4'd0;
        launch_vy  = 4'd0;
        launch_req = 1'b1;
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("pr_busy", {31'b0, busy}, 1);
        seen_ack = 1'b0;
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            if (launch_ack === 1'b1) seen_ack = 1'b1;
            @(negedge clk);
            cyc++;
        end
        check("pr_no_ack_busy", {31'b0, seen_ack}, 0);
        for (int i = 0; i < 5 && !seen_ack; i++) begin
            if (launch_ack === 1'b1) seen_ack = 1'b1;
            else @(negedge clk);
        end
        launch_req = 1'b0;
        check("pr_ack_after", {31'b0, seen_ack}, 1);
        check("pr_balls", {29'b0, balls}, 3'b011);
        check("pr_x0", sx(0), 101);
        check("pr_x1", sx(1), 300);

        // Overrun: second tick while busy is ignored but recorded
        @(negedge clk);
        check("ov_before", {31'b0, overrun}, 0);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        check("ov_set", {31'b0, overrun}, 1);
        cyc = 0;
        while (busy === 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("ov_done", {31'b0, busy}, 0);
        check("ov_sticky", {31'b0, overrun}, 1);
        check("ov_x0_once", sx(0), 102);

        // Reset in the middle of an update
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        @(negedge clk);
        check("mr_busy", {31'b0, busy}, 1);
        rst_n = 1'b0;
        #1;
        check("mr_xs", xs, 0);
        check("mr_ys", ys, 0);
        check("mr_balls", {29'b0, balls}, 0);
        check("mr_busy0", {31'b0, busy}, 0);
        check("mr_overrun", {31'b0, overrun}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
